// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   OWNER_*  : encoding of the owner output (which requester's value is on display)
//   DIGITS   : number of scanned digits per frame
//   SEL_W    : width of the digit-select index
//   owner_e  : owner state machine encoding, aligned with OWNER_*
package disp_pkg;

  localparam logic [1:0] OWNER_IDLE = 2'd0;
  localparam logic [1:0] OWNER_A    = 2'd1;
  localparam logic [1:0] OWNER_B    = 2'd2;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    StIdle = OWNER_IDLE,
    StA    = OWNER_A,
    StB    = OWNER_B
  } owner_e;

endpackage

// File: rtl/scan_timer.sv
// Digit-slot divider and digit-select counter for the scan controller.
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   sel        out  active digit index 0..DIGITS-1
//   slot_tick  out  high on the last cycle of each digit slot
//   frame_tick out  high on the last cycle of the last digit (frame boundary)
module scan_timer
  import disp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned DIV_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [SEL_W-1:0] sel,
  output logic             slot_tick,
  output logic             frame_tick
);

  localparam logic [DIV_W-1:0] DivMax = DIV_W'(CLK_DIV - 1);
  localparam logic [SEL_W-1:0] SelMax = SEL_W'(DIGITS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  // With CLK_DIV == 1 DivMax is 0, so div stays 0 and slot_tick is constantly high.
  assign slot_tick  = (div_q == DivMax);
  assign frame_tick = slot_tick && (sel_q == SelMax);

  always_comb begin
    div_d = slot_tick ? '0 : div_q + 1'b1;
    sel_d = sel_q;
    if (slot_tick) begin
      sel_d = (sel_q == SelMax) ? '0 : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      sel_q <= '0;
    end else begin
      div_q <= div_d;
      sel_q <= sel_d;
    end
  end

  assign sel = sel_q;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan sequencer and two-requester arbiter for the 8-digit seven-segment display.
// Displayed values change only at frame boundaries, so a frame never mixes sources.
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   req_a, val_a       requester A level request and 32-bit value
//   ack_a              one-cycle pulse when val_a has been captured
//   req_b, val_b       requester B (debug monitor), same protocol
//   ack_b              one-cycle pulse when val_b has been captured
//   outval1, outval2   upper / lower four digits for the display stage
//   sel                active digit index
//   frame_tick         pulse on the last cycle of digit 7
//   owner              source of the current outvals (OWNER_IDLE/A/B)
// Build option:
//   DISP_PRIO_EN  when defined, A has fixed priority over B; otherwise round-robin.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned DIV_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic [31:0]      val_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [31:0]      val_b,
  output logic             ack_b,
  output logic [15:0]      outval1,
  output logic [15:0]      outval2,
  output logic [SEL_W-1:0] sel,
  output logic             frame_tick,
  output logic [1:0]       owner
);

  logic slot_tick;
  logic boundary;
  logic grant_a, grant_b;

  owner_e      state_q, state_d;
  logic        last_b_q, last_b_d;  // 1: last grant went to B
  logic [15:0] outval1_q, outval1_d;
  logic [15:0] outval2_q, outval2_d;
  logic        ack_a_q, ack_b_q;

  scan_timer #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_scan_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .sel        (sel),
    .slot_tick  (slot_tick),
    .frame_tick (frame_tick)
  );

  // frame_tick already implies slot_tick; the extra term keeps the qualification explicit.
  assign boundary = slot_tick && frame_tick;

  // Arbitration on the request levels seen in the boundary cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (boundary) begin
`ifdef DISP_PRIO_EN
      grant_a = req_a;
`else
      grant_a = req_a && (!req_b || last_b_q);
`endif
      grant_b = req_b && !grant_a;
    end
  end

  // Owner FSM: state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner FSM: next state. Holds when nothing is granted; never returns to StIdle.
  always_comb begin
    state_d = state_q;
    if (grant_a) begin
      state_d = StA;
    end else if (grant_b) begin
      state_d = StB;
    end
  end

  // Owner FSM: outputs.
  always_comb begin
    owner = state_q;
  end

  // Capture datapath.
  always_comb begin
    last_b_d  = last_b_q;
    outval1_d = outval1_q;
    outval2_d = outval2_q;
    if (grant_a) begin
      last_b_d  = 1'b0;
      outval1_d = val_a[31:16];
      outval2_d = val_a[15:0];
    end else if (grant_b) begin
      last_b_d  = 1'b1;
      outval1_d = val_b[31:16];
      outval2_d = val_b[15:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_b_q  <= 1'b1;
      outval1_q <= '0;
      outval2_q <= '0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
    end else begin
      last_b_q  <= last_b_d;
      outval1_q <= outval1_d;
      outval2_q <= outval2_d;
      ack_a_q   <= grant_a;
      ack_b_q   <= grant_b;
    end
  end

  assign outval1 = outval1_q;
  assign outval2 = outval2_q;
  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: CLK_DIV = 4 main instance (32-cycle frame)
// plus a CLK_DIV = 1 instance for the minimum-divider case.
module tb_disp_scan_ctrl;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, req_a, req_b, ack_a, ack_b, frame_tick;
  logic [31:0] val_a, val_b;
  logic [15:0] outval1, outval2;
  logic [2:0]  sel;
  logic [1:0]  owner;

  logic        reset1_n, req_a1, req_b1, ack_a1, ack_b1, frame_tick1;
  logic [31:0] val_a1, val_b1;
  logic [15:0] outval1_1, outval2_1;
  logic [2:0]  sel1;
  logic [1:0]  owner1;

  disp_scan_ctrl #(.CLK_DIV(4), .DIV_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a(req_a), .val_a(val_a), .ack_a(ack_a),
    .req_b(req_b), .val_b(val_b), .ack_b(ack_b),
    .outval1(outval1), .outval2(outval2), .sel(sel),
    .frame_tick(frame_tick), .owner(owner)
  );

  disp_scan_ctrl #(.CLK_DIV(1), .DIV_W(1)) dut1 (
    .clock(clock), .reset_n(reset1_n),
    .req_a(req_a1), .val_a(val_a1), .ack_a(ack_a1),
    .req_b(req_b1), .val_b(val_b1), .ack_b(ack_b1),
    .outval1(outval1_1), .outval2(outval2_1), .sel(sel1),
    .frame_tick(frame_tick1), .owner(owner1)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int pos    = 0;  // bench's own frame position, 0..31

  typedef struct {
    logic        ra;
    logic        rb;
    logic [31:0] va;
    logic [31:0] vb;
    logic        ea;
    logic        eb;
    logic [1:0]  eo;
    logic [31:0] ev;  // expected {outval1, outval2}
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    pos = (pos + 1) % 32;
  endtask

  task automatic step_to(input int p);
    do step(); while (pos != p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
`ifdef DISP_PRIO_EN
    tbl[0] = '{1'b1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1, 1'b0, 2'd1, 32'hAAAA_0001};
    tbl[1] = '{1'b1, 1'b1, 32'hAAAA_0003, 32'hBBBB_0004, 1'b1, 1'b0, 2'd1, 32'hAAAA_0003};
    tbl[2] = '{1'b1, 1'b1, 32'hAAAA_0005, 32'hBBBB_0006, 1'b1, 1'b0, 2'd1, 32'hAAAA_0005};
    tbl[3] = '{1'b1, 1'b1, 32'hAAAA_0007, 32'hBBBB_0008, 1'b1, 1'b0, 2'd1, 32'hAAAA_0007};
`else
    tbl[0] = '{1'b1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0, 1'b1, 2'd2, 32'hBBBB_0002};
    tbl[1] = '{1'b1, 1'b1, 32'hAAAA_0003, 32'hBBBB_0004, 1'b1, 1'b0, 2'd1, 32'hAAAA_0003};
    tbl[2] = '{1'b1, 1'b1, 32'hAAAA_0005, 32'hBBBB_0006, 1'b0, 1'b1, 2'd2, 32'hBBBB_0006};
    tbl[3] = '{1'b1, 1'b1, 32'hAAAA_0007, 32'hBBBB_0008, 1'b1, 1'b0, 2'd1, 32'hAAAA_0007};
`endif
    tbl[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1, 32'hAAAA_0007};
    tbl[5] = '{1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, 2'd2, 32'hCAFE_F00D};
    tbl[6] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 2'd1, 32'hDEAD_BEEF};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1, 32'hDEAD_BEEF};

    reset_n  = 1'b0;  req_a  = 1'b0;  req_b  = 1'b0;  val_a  = '0;  val_b  = '0;
    reset1_n = 1'b0;  req_a1 = 1'b0;  req_b1 = 1'b0;  val_a1 = '0;  val_b1 = '0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_sel", sel, 0);
    check("rst_outvals", {outval1, outval2}, 0);
    check("rst_owner", owner, 0);
    check("rst_acks", {ack_a, ack_b}, 0);
    check("rst_frame_tick", frame_tick, 0);

    // Scan sequence after release; A requests at cycle 5 and is served at cycle 32
    reset_n = 1'b1;
    pos     = 0;
    for (int c = 0; c < 32; c++) begin
      check("scan_sel", sel, c / 4);
      check("scan_frame_tick", frame_tick, c == 31);
      check("scan_no_ack_a", ack_a, 0);
      if (c == 5) begin
        req_a = 1'b1;
        val_a = 32'h1234_ABCD;
      end
      step();
    end
    check("first_ack_a", ack_a, 1);
    check("first_ack_b", ack_b, 0);
    check("first_outvals", {outval1, outval2}, 32'h1234_ABCD);
    check("first_owner", owner, 1);
    check("first_sel", sel, 0);
    req_a = 1'b0;
    step();
    check("first_ack_pulse", ack_a, 0);
    check("first_hold_owner", owner, 1);

    // One table entry per frame
    for (int i = 0; i < 8; i++) begin
      req_a = tbl[i].ra;
      req_b = tbl[i].rb;
      val_a = tbl[i].va;
      val_b = tbl[i].vb;
      step_to(0);
      check("tbl_ack_a", ack_a, tbl[i].ea);
      check("tbl_ack_b", ack_b, tbl[i].eb);
      check("tbl_owner", owner, tbl[i].eo);
      check("tbl_outvals", {outval1, outval2}, tbl[i].ev);
      check("tbl_sel", sel, 0);
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      check("tbl_acks_low", {ack_a, ack_b}, 0);
    end

    // B withdraws before the boundary: no capture, no ack
    step_to(10);
    req_b = 1'b1;
    val_b = 32'h1111_2222;
    step_to(20);
    req_b = 1'b0;
    step_to(0);
    check("withdraw_ack_b", ack_b, 0);
    check("withdraw_ack_a", ack_a, 0);
    check("withdraw_owner", owner, 1);
    check("withdraw_outvals", {outval1, outval2}, 32'hDEAD_BEEF);

    // Reset mid-frame with A pending
    step();
    req_a = 1'b1;
    val_a = 32'h5555_6666;
    step_to(20);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_owner", owner, 0);
    check("async_rst_outvals", {outval1, outval2}, 0);
    check("async_rst_sel", sel, 0);
    check("async_rst_acks", {ack_a, ack_b}, 0);
    req_a = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    pos     = 0;
    for (int c = 0; c < 32; c++) begin
      check("rst2_sel", sel, c / 4);
      check("rst2_no_ack_a", ack_a, 0);
      step();
    end
    check("rst2_idle_owner", owner, 0);
    check("rst2_no_ack", {ack_a, ack_b}, 0);

    // After reset last_grant is B, so a tie goes to A in either mode
    req_a = 1'b1;  val_a = 32'h7777_8888;
    req_b = 1'b1;  val_b = 32'h9999_AAAA;
    step_to(0);
    check("tie_ack_a", ack_a, 1);
    check("tie_ack_b", ack_b, 0);
    check("tie_owner", owner, 1);
    check("tie_outvals", {outval1, outval2}, 32'h7777_8888);
    req_a = 1'b0;
    req_b = 1'b0;

    // CLK_DIV = 1 instance
    @(posedge clock);
    #1;
    check("div1_rst_owner", owner1, 0);
    check("div1_rst_sel", sel1, 0);
    reset1_n = 1'b1;
    req_a1   = 1'b1;
    val_a1   = 32'h0F0F_F0F0;
    for (int c = 0; c < 16; c++) begin
      check("div1_sel", sel1, c % 8);
      check("div1_frame_tick", frame_tick1, (c % 8) == 7);
      if (c < 8) check("div1_no_ack_early", ack_a1, 0);
      if (c == 8) begin
        check("div1_ack_a", ack_a1, 1);
        check("div1_owner", owner1, 1);
        check("div1_outvals", {outval1_1, outval2_1}, 32'h0F0F_F0F0);
        req_a1 = 1'b0;
      end
      if (c == 9) check("div1_ack_pulse", ack_a1, 0);
      @(posedge clock);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
